regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the RISC-V datapath; next generation of the 32x32, 2-read/1-write register file.
- Generalised in data width, depth and read-port count.
- Adds:
  - a second write port with defined priority
  - x0 hardwired to zero
  - write-to-read bypass
  - a synchronous clear sequencer that zeroes the array after reset and reports Ready.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of registers (power of two, >= 2)
- AW, $clog2(NREGS), address width (derived; not overridden)
- NREAD, 2, number of read ports (>= 1)

Ports:
- Clk  in  1  clock; all state updates on posedge
- Rst  in  1  synchronous active-high reset
- raddr  in  NREAD*AW  read addresses; port i at bits [i*AW +: AW]
- rdata  out  NREAD*XLEN  read data; port i at bits [i*XLEN +: XLEN]
- waddrA  in  AW  write port A address
- wdataA  in  XLEN  write port A data
- RegWriteA  in  1  write port A enable
- waddrB  in  AW  write port B address
- wdataB  in  XLEN  write port B data
- RegWriteB  in  1  write port B enable
- Ready  out  1  high when the array is cleared and accepting writes
- WrConflict  out  1  registered; pulses one cycle after A and B wrote the same nonzero address

Behaviour:
- Clock and reset: one clock Clk; reset Rst is synchronous and active-high.
- Reset response: Rst sampled high at posedge sets:
  - state <= CLEAR, clr_idx <= 0
  - Ready <= 0, WrConflict <= 0
  - Array contents are not changed by Rst itself.
- CLEAR state:
  - Each cycle: Reg[clr_idx] <= 0, clr_idx <= clr_idx + 1.
  - When clr_idx == NREGS-1: write that entry, go to RUN, Ready <= 1.
  - Ready therefore rises exactly NREGS cycles after the last Rst-high edge.
- During CLEAR:
  - Both write ports are ignored (no array update, no WrConflict).
  - All rdata ports read 0.
- Rst high mid-CLEAR: the sequence restarts at clr_idx = 0.
- Rst high in RUN: drops Ready and re-enters CLEAR next cycle.
- RUN state writes (posedge):
  - If RegWriteA and waddrA != 0: Reg[waddrA] <= wdataA.
  - If RegWriteB and waddrB != 0: Reg[waddrB] <= wdataB.
  - Same address on both ports: B wins; WrConflict <= 1 on the next edge, otherwise WrConflict <= 0.
  - Writes to address 0 are discarded; Reg[0] always reads 0.
- Reads (combinational, every port independent):
  - raddr == 0 -> 0.
  - Else if RUN, RegWriteB and waddrB == raddr -> wdataB (bypass).
  - Else if RUN, RegWriteA and waddrA == raddr -> wdataA (bypass).
  - Else -> Reg[raddr].
  - Bypass priority matches write priority, so a read in the cycle of a write returns the value the register will hold after the edge.
- Addresses: all AW bits are used; no address masking; any write to 1..NREGS-1 is legal.
- Width: data is stored and returned unmodified, no extension or truncation.
- Implementation: the array is flops (no reset on the storage itself); the clear is done only by the sequencer.

Test Plan:
- Reset/clear:
  - Stimulus: Rst high 1 cycle, then low; NREGS=32; raddr port0 = 5 throughout.
  - Response: Ready = 0 for 32 cycles, rises on the 32nd edge after Rst; rdata0 = 0 throughout; writes issued during CLEAR to x5 = 0x1234 are lost (x5 reads 0 after Ready).
- Basic write/read and x0:
  - Stimulus: in RUN write A: x5 = 20, x6 = 25 on successive cycles; write A: x0 = 0xDEADBEEF.
  - Response: raddr0 = 5 / raddr1 = 6 read 20 / 25 after the edges; raddr = 0 reads 0 at all times.
- Bypass:
  - Stimulus: raddr0 = 7 with RegWriteA, waddrA = 7, wdataA = 15 in the same cycle.
  - Response: rdata0 = 15 before the edge and after it.
- Dual write, same address:
  - Stimulus: A writes x28 = 50 and B writes x28 = 9 in one cycle.
  - Response: bypass read 9; x28 = 9 after the edge; WrConflict = 1 for exactly one cycle after.
  - Follow-up: A x29 = 5, B x30 = 2 -> both written, WrConflict = 0.
- Reset mid-operation:
  - Stimulus: assert Rst in RUN with x31 = 9; assert Rst again at clear cycle 10; then release.
  - Response: Ready drops next edge; the clear restarts (32 more cycles to Ready); x31 reads 0 afterwards.
- Parameter sweep:
  - Stimulus: NREGS = 16, XLEN = 64, NREAD = 3; write A x15 = 0xFFFF_FFFF_0000_0001; read x15 on all 3 ports.
  - Response: Ready after 16 cycles; all 3 ports return the full 64-bit value.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with x0, write bypass, dual write and clear sequencer
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  input  logic [AW-1:0]         waddrA,
  input  logic [XLEN-1:0]       wdataA,
  input  logic                  RegWriteA,
  input  logic [AW-1:0]         waddrB,
  input  logic [XLEN-1:0]       wdataB,
  input  logic                  RegWriteB,
  output logic                  Ready,
  output logic                  WrConflict
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [AW-1:0] clr_idx, clr_n;
  logic [XLEN-1:0] regs [NREGS];
  logic run, we_a, we_b, conflict_n;
  assign run = state == RUN;
  assign Ready = run;
  assign we_a = run && RegWriteA && waddrA != '0;
  assign we_b = run && RegWriteB && waddrB != '0;
  always_comb begin
    state_n = state == CLEAR && clr_idx == AW'(NREGS - 1) ? RUN : state;
    clr_n = state == CLEAR ? clr_idx + AW'(1) : clr_idx;
    conflict_n = we_a && we_b && waddrA == waddrB;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= CLEAR;
      clr_idx <= '0;
      WrConflict <= 1'b0;
    end else begin
      state <= state_n;
      clr_idx <= clr_n;
      WrConflict <= conflict_n;
    end
  end
  // storage has no reset; the sequencer zeroes one entry per cycle while clearing
  always_ff @(posedge Clk) begin
    if (!run) regs[clr_idx] <= '0;
    else begin
      if (we_a) regs[waddrA] <= wdataA;
      if (we_b) regs[waddrB] <= wdataB;
    end
  end
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] a;
    assign a = raddr[g*AW +: AW];
    assign rdata[g*XLEN +: XLEN] = a == '0 || !run ? '0 :
                                   we_b && waddrB == a ? wdataB :
                                   we_a && waddrA == a ? wdataA : regs[a];
  end
endmodule
